// File: rtl/onehot_pulse_decoder_pkg.sv
// rtl/onehot_pulse_decoder_pkg.sv - shared constants, FSM states and line decode helper
package onehot_pulse_decoder_pkg;

  localparam int NUM_LINES = 8;
  localparam int CODE_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [NUM_LINES-1:0] decode_line(input logic [CODE_W-1:0] c);
    decode_line    = '0;
    decode_line[c] = 1'b1;
  endfunction

endpackage

// File: rtl/onehot_pulse_decoder_if.sv
// rtl/onehot_pulse_decoder_if.sv - code handshake, abort and strobe bundle for onehot_pulse_decoder
interface onehot_pulse_decoder_if;
  import onehot_pulse_decoder_pkg::*;

  logic [CODE_W-1:0]    code;
  logic                 code_valid;
  logic                 code_ready;
  logic                 abort;
  logic [NUM_LINES-1:0] y;
  logic                 busy;
  logic                 done;

  modport master (
    output code, code_valid, abort,
    input  code_ready, y, busy, done
  );

  modport slave (
    input  code, code_valid, abort,
    output code_ready, y, busy, done
  );

endinterface

// File: rtl/onehot_pulse_decoder_timer.sv
// rtl/onehot_pulse_decoder_timer.sv - onehot_pulse_timer: loadable down-counter with zero flag
module onehot_pulse_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Saturates at zero so an idle timer always reports zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/onehot_pulse_decoder.sv
// rtl/onehot_pulse_decoder.sv - sequenced 3-to-8 pulse decoder; ONEHOT_DEC_SKID_EN adds a one-entry pending slot
module onehot_pulse_decoder
  import onehot_pulse_decoder_pkg::*;
#(
  parameter int PULSE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_pulse_decoder_if.slave bus
);

  localparam int               CNT_W    = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_LEN - 1);

  state_t               state;
  logic [NUM_LINES-1:0] y_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 xfer;
  logic                 launch;
  logic [CODE_W-1:0]    launch_code;
  logic                 cnt_zero;

`ifdef ONEHOT_DEC_SKID_EN
  logic              pend_valid;
  logic [CODE_W-1:0] pend_code;

  assign bus.code_ready = rst_n && !bus.abort && ((state == ST_IDLE) || !pend_valid);
  assign xfer           = bus.code_valid && bus.code_ready;
  // GAP hands straight over to the next pulse, either from the slot or a same-cycle transfer.
  assign launch         = ((state == ST_IDLE) && xfer) ||
                          ((state == ST_GAP) && (pend_valid || xfer));
  assign launch_code    = ((state == ST_GAP) && pend_valid) ? pend_code : bus.code;
`else
  assign bus.code_ready = rst_n && !bus.abort && (state == ST_IDLE);
  assign xfer           = bus.code_valid && bus.code_ready;
  assign launch         = (state == ST_IDLE) && xfer;
  assign launch_code    = bus.code;
`endif

  onehot_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (bus.abort),
    .load     (launch),
    .load_val (LOAD_VAL),
    .dec      (state == ST_PULSE),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      y_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef ONEHOT_DEC_SKID_EN
      pend_valid <= 1'b0;
      pend_code  <= '0;
`endif
    end else if (bus.abort) begin
      state  <= ST_IDLE;
      y_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef ONEHOT_DEC_SKID_EN
      pend_valid <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (launch) begin
        state  <= ST_PULSE;
        y_q    <= decode_line(launch_code);
        busy_q <= 1'b1;
`ifdef ONEHOT_DEC_SKID_EN
        pend_valid <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end
          ST_PULSE: begin
`ifdef ONEHOT_DEC_SKID_EN
            if (xfer) begin
              pend_valid <= 1'b1;
              pend_code  <= bus.code;
            end
`endif
            if (cnt_zero) begin
              state  <= ST_GAP;
              y_q    <= '0;
              done_q <= 1'b1;
            end
          end
          ST_GAP: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            y_q    <= '0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb/tb_onehot_pulse_decoder.sv - randomized bench with busy-window reference model, PULSE_LEN 4 and 1
module tb_onehot_pulse_decoder;

`ifdef ONEHOT_DEC_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] code = 3'd0;
  logic       code_valid = 1'b0;
  logic       abort = 1'b0;

  int checks = 0;
  int errors = 0;

  onehot_pulse_decoder_if bus4 ();
  onehot_pulse_decoder_if bus1 ();

  assign bus4.code       = code;
  assign bus4.code_valid = code_valid;
  assign bus4.abort      = abort;
  assign bus1.code       = code;
  assign bus1.code_valid = code_valid;
  assign bus1.abort      = abort;

  onehot_pulse_decoder #(.PULSE_LEN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  onehot_pulse_decoder #(.PULSE_LEN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  logic [7:0] ya [2];
  logic       ba [2];
  logic       da [2];
  logic       ra [2];
  assign ya[0] = bus4.y;          assign ya[1] = bus1.y;
  assign ba[0] = bus4.busy;       assign ba[1] = bus1.busy;
  assign da[0] = bus4.done;       assign da[1] = bus1.done;
  assign ra[0] = bus4.code_ready; assign ra[1] = bus1.code_ready;

  // Model: each accepted code owns a busy window of PULSE_LEN strobe cycles plus one gap cycle.
  int         pl  [2] = '{4, 1};
  int         rem [2];
  logic [2:0] cur [2];
  bit         pv  [2];
  logic [2:0] pc  [2];

  function automatic bit exp_ready(int i);
    return rst_n && !abort && ((rem[i] == 0) || (SKID && !pv[i]));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int prio_enc(logic [7:0] v);
    int r = -1;
    for (int k = 0; k < 8; k++) if (v[k]) r = k;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        rem[i] <= 0;
        pv[i]  <= 1'b0;
        cur[i] <= 3'd0;
        pc[i]  <= 3'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic int         r     = rem[i];
        automatic bit         p     = pv[i];
        automatic logic [2:0] pcode = pc[i];
        automatic logic [2:0] ccode = cur[i];
        automatic bit         x     = code_valid && exp_ready(i);
        automatic bit         was_busy = (r > 0);
        if (abort) begin
          r = 0;
          p = 1'b0;
        end else begin
          if (r > 0) r--;
          if (x) begin
            if (!was_busy) begin
              r = pl[i] + 1; ccode = code;
            end else begin
              p = 1'b1; pcode = code;
            end
          end
          if (was_busy && (r == 0) && p) begin
            r = pl[i] + 1; ccode = pcode; p = 1'b0;
          end
        end
        rem[i] <= r;
        pv[i]  <= p;
        pc[i]  <= pcode;
        cur[i] <= ccode;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        automatic logic [7:0] ey = 8'd0;
        if (rem[i] > 1) ey[cur[i]] = 1'b1;
        chk($sformatf("L%0d_y", pl[i]), ya[i], ey);
        chk($sformatf("L%0d_busy", pl[i]), ba[i], rem[i] > 0);
        chk($sformatf("L%0d_done", pl[i]), da[i], rem[i] == 1);
        chk($sformatf("L%0d_ready", pl[i]), ra[i], exp_ready(i));
        chk($sformatf("L%0d_onehot0", pl[i]), $onehot0(ya[i]), 1);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(2);
    chk("rst_y", bus4.y, 8'h00);
    chk("rst_busy", bus4.busy, 0);
    chk("rst_done", bus4.done, 0);
    chk("rst_ready_low", bus4.code_ready, 0);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", bus4.code_ready, 1);

    // code 5: strobe N+1..N+4, gap N+5, ready again N+6
    code = 3'd5; code_valid = 1'b1;
    step(1);
    code_valid = 1'b0;
    chk("c5_y_first", bus4.y, 8'h20);
    chk("c5_prio_enc", prio_enc(bus4.y), 5);
    chk("c5_len1_y", bus1.y, 8'h20);
    step(1);
    chk("c5_len1_gap_done", bus1.done, 1);
    chk("c5_len1_gap_y", bus1.y, 8'h00);
    step(2);
    chk("c5_y_last", bus4.y, 8'h20);
    step(1);
    chk("c5_gap_y", bus4.y, 8'h00);
    chk("c5_gap_done", bus4.done, 1);
    step(1);
    chk("c5_ready_back", bus4.code_ready, 1);
    chk("c5_idle_done", bus4.done, 0);

    // abort in cycle 2 of a code=3 pulse, with another code offered meanwhile
    code = 3'd3; code_valid = 1'b1;
    step(1);
    code = 3'd6;
    step(1);
    chk("ab_y_before", bus4.y, 8'h08);
    abort = 1'b1; code_valid = 1'b0;
    #1 chk("ab_ready_forced_low", bus4.code_ready, 0);
    step(1);
    abort = 1'b0;
    chk("ab_y", bus4.y, 8'h00);
    chk("ab_no_done", bus4.done, 0);
    chk("ab_busy", bus4.busy, 0);
    #1 chk("ab_ready_idle", bus4.code_ready, 1);
    step(3);

    // asynchronous reset mid-pulse
    code = 3'd1; code_valid = 1'b1;
    step(1);
    code_valid = 1'b0;
    chk("ar_y_before", bus4.y, 8'h02);
    #1 rst_n = 1'b0;
    #1 chk("ar_y_async", bus4.y, 8'h00);
    chk("ar_done", bus4.done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("ar_ready", bus4.code_ready, 1);
    step(1);

    // all eight codes back-to-back against the PULSE_LEN=4 instance
    code_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      automatic int t = 0;
      code = 3'(c);
      while (!bus4.code_ready && t < 20) begin
        step(1);
        t++;
      end
      if (t >= 20) begin
        errors++;
        $display("FAIL b2b_ready_timeout actual=0 required=1");
      end
      step(1);
    end
    code_valid = 1'b0;
    step(8);

    for (int n = 0; n < 3000; n++) begin
      code       = 3'($urandom_range(0, 7));
      code_valid = ($urandom_range(0, 3) != 0);
      abort      = ($urandom_range(0, 40) == 0);
      step(1);
    end
    code_valid = 1'b0;
    abort = 1'b0;
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
